pmux_lut_array: RTL and testbench

- Parametrised successor to the fixed 4-entry programmable mux.
- CHANNELS independent 2^SEL_W-entry lookup muxes are configured through one serial chain.
- Single-clock shift register with a valid/ready per-bit handshake, a frame sequencer, and a shadow/active split so live outputs never see partial configuration.
- Sits in programmable-fabric tiles; prog_out daisy-chains to the next tile.

---
 rtl/pmux_pkg.sv | 16 +
 rtl/pmux_cfg_seq.sv | 71 +++++++
 rtl/pmux_lut_array.sv | 73 +++++++
 tb/tb_pmux_lut_array.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pmux_pkg.sv
// Shared types and sizing helpers for the programmable LUT mux array.
package pmux_pkg;

  localparam int PMUX_MAX_SEL_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } pmux_state_e;

  function automatic int pmux_depth(input int sel_w, input int channels);
    return channels * (1 << sel_w);
  endfunction

endpackage

// File: rtl/pmux_cfg_seq.sv
// Frame sequencer for the serial configuration chain: handshake, bit counter, commit strobe.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for cfg_start; active config driving the outputs
// ST_SHIFT  | accepting bits on prog_valid, counting toward DEPTH
// ST_COMMIT | one cycle: shadow copied into active, cfg_done follows
import pmux_pkg::*;

module pmux_cfg_seq #(
  parameter int DEPTH = 4
) (
  input  logic prog_clk,
  input  logic prog_rst_n,
  input  logic cfg_start,
  input  logic cfg_abort,
  input  logic prog_valid,
  output logic shift_en,
  output logic commit,
  output logic prog_ready,
  output logic busy,
  output logic cfg_done
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  pmux_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  assign prog_ready = (state_q == ST_SHIFT);
  assign busy       = (state_q != ST_IDLE);
  assign cfg_done   = done_q;
  assign commit     = (state_q == ST_COMMIT);
  // Abort wins over a valid bit presented in the same cycle.
  assign shift_en   = prog_ready && prog_valid && !cfg_abort;

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_start && !cfg_abort) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
          end
        end
        ST_SHIFT: begin
          if (cfg_abort) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (shift_en) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pmux_lut_array.sv
// CHANNELS independent 2^SEL_W-entry lookup muxes loaded through one daisy-chainable
// serial shift register; a shadow/active split keeps outputs glitch-free during loads.
import pmux_pkg::*;

module pmux_lut_array #(
  parameter int SEL_W    = 2,
  parameter int CHANNELS = 1
) (
  input  logic                      prog_clk,
  input  logic                      prog_rst_n,
  input  logic                      cfg_start,
  input  logic                      cfg_abort,
  input  logic                      prog_valid,
  input  logic                      prog_in,
  output logic                      prog_ready,
  output logic                      prog_out,
  output logic                      busy,
  output logic                      cfg_done,
  input  logic [CHANNELS*SEL_W-1:0] sel,
  output logic [CHANNELS-1:0]       out
);

  localparam int ENTRIES = 1 << SEL_W;
  localparam int DEPTH   = pmux_depth(SEL_W, CHANNELS);

  logic             shift_en;
  logic             commit;
  logic [DEPTH-1:0] shift_q;
  logic [DEPTH-1:0] active_q;

  pmux_cfg_seq #(
    .DEPTH(DEPTH)
  ) u_seq (
    .prog_clk  (prog_clk),
    .prog_rst_n(prog_rst_n),
    .cfg_start (cfg_start),
    .cfg_abort (cfg_abort),
    .prog_valid(prog_valid),
    .shift_en  (shift_en),
    .commit    (commit),
    .prog_ready(prog_ready),
    .busy      (busy),
    .cfg_done  (cfg_done)
  );

  // First bit of a frame ends up in the MSB; the bit pushed out feeds the next tile.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= {shift_q[DEPTH-2:0], prog_in};
    end
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      active_q <= '0;
    end else if (commit) begin
      active_q <= shift_q;
    end
  end

  assign prog_out = shift_q[DEPTH-1];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [SEL_W-1:0]   sel_c;
    logic [ENTRIES-1:0] lut_c;
    assign sel_c  = sel[c*SEL_W +: SEL_W];
    assign lut_c  = active_q[c*ENTRIES +: ENTRIES];
    assign out[c] = lut_c[sel_c];
  end

endmodule

// File: tb/tb_pmux_lut_array.sv
// Scoreboard bench for pmux_lut_array (SEL_W=2, CHANNELS=2) with a second tile daisy-chained.
module tb_pmux_lut_array;

  logic       prog_clk = 1'b0;
  logic       prog_rst_n;
  logic       cfg_start, cfg_abort, prog_valid, prog_in;
  logic [3:0] sel, sel_b;
  logic       ready_a, pout_a, busy_a, done_a;
  logic       ready_b, pout_b, busy_b, done_b;
  logic [1:0] out_a, out_b;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  always #5 prog_clk = ~prog_clk;

  pmux_lut_array #(.SEL_W(2), .CHANNELS(2)) dut (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .cfg_start(cfg_start),
    .cfg_abort(cfg_abort), .prog_valid(prog_valid), .prog_in(prog_in),
    .prog_ready(ready_a), .prog_out(pout_a), .busy(busy_a), .cfg_done(done_a),
    .sel(sel), .out(out_a)
  );

  pmux_lut_array #(.SEL_W(2), .CHANNELS(2)) dut_b (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .cfg_start(cfg_start),
    .cfg_abort(cfg_abort), .prog_valid(prog_valid), .prog_in(pout_a),
    .prog_ready(ready_b), .prog_out(pout_b), .busy(busy_b), .cfg_done(done_b),
    .sel(sel_b), .out(out_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Walk every select value; channel 0 uses bits [3:0] of the config, channel 1 bits [7:4].
  task automatic sweep(input string tag, input logic [7:0] exp_a, input bit chk_b,
                       input logic [7:0] exp_b);
    logic [7:0] ea, eb;
    ea = exp_a;
    eb = exp_b;
    for (int s = 0; s < 4; s++) begin
      sel   = {s[1:0], s[1:0]};
      sel_b = {s[1:0], s[1:0]};
      #1;
      chk({tag, "_a"}, out_a, {ea[4+s], ea[s]});
      if (chk_b) chk({tag, "_b"}, out_b, {eb[4+s], eb[s]});
    end
  endtask

  always @(negedge prog_clk) begin
    if (done_a === 1'b1) begin
      chk("done_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) sweep("commit_out", exp_q.pop_front(), 1'b0, 8'h00);
    end
  end

  task automatic send_frame(input logic [7:0] d, input bit gaps, input int abort_at,
                            input int start_at);
    @(negedge prog_clk);
    if (abort_at < 0) exp_q.push_back(d);
    cfg_start = 1'b1;
    @(negedge prog_clk);
    cfg_start = 1'b0;
    chk("busy_shift", busy_a, 1);
    chk("ready_shift", ready_a, 1);
    for (int i = 0; i < 8; i++) begin
      prog_valid = 1'b1;
      prog_in    = d[7-i];
      cfg_start  = (i == start_at);
      if (i == abort_at) cfg_abort = 1'b1;
      chk("ready_pre", ready_a, 1);
      @(negedge prog_clk);
      prog_valid = 1'b0;
      cfg_start  = 1'b0;
      if (i == abort_at) begin
        cfg_abort = 1'b0;
        chk("busy_abort", busy_a, 0);
        chk("ready_abort", ready_a, 0);
        @(negedge prog_clk);
        chk("done_abort", done_a, 0);
        @(negedge prog_clk);
        return;
      end
      if (gaps && i < 7) begin
        repeat (2) begin
          @(negedge prog_clk);
          chk("ready_stall", ready_a, 1);
        end
      end
    end
    chk("ready_last", ready_a, 0);
    chk("busy_commit", busy_a, 1);
    chk("done_commit", done_a, 0);
    @(negedge prog_clk);
    chk("done_pulse", done_a, 1);
    chk("busy_idle", busy_a, 0);
    @(negedge prog_clk);
    chk("done_single", done_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    prog_rst_n = 1'b0;
    cfg_start  = 1'b0;
    cfg_abort  = 1'b0;
    prog_valid = 1'b0;
    prog_in    = 1'b0;
    sel        = '0;
    sel_b      = '0;
    #2;
    chk("rst_busy", busy_a, 0);
    chk("rst_ready", ready_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pout", pout_a, 0);
    sweep("rst_out", 8'h00, 1'b1, 8'h00);
    repeat (2) @(negedge prog_clk);
    prog_rst_n = 1'b1;

    // Plain frame: channel 0 reads 0,1,1,0 and channel 1 reads 1,0,0,1.
    send_frame(8'h96, 1'b0, -1, -1);
    sweep("full_out", 8'h96, 1'b0, 8'h00);

    // Mid-cycle reset clears everything immediately.
    @(negedge prog_clk);
    #2 prog_rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy_a, 0);
    chk("mrst_pout", pout_a, 0);
    sweep("mrst_out", 8'h00, 1'b1, 8'h00);
    @(negedge prog_clk);
    prog_rst_n = 1'b1;

    // Daisy chain: B receives A's previous shift contents.
    send_frame(8'h96, 1'b0, -1, -1);
    chk("daisy_pout_a", pout_a, 1);
    chk("daisy_pout_b", pout_b, 0);
    sweep("daisy1", 8'h96, 1'b1, 8'h00);
    send_frame(8'h3C, 1'b0, -1, -1);
    sweep("daisy2", 8'h3C, 1'b1, 8'h96);

    // Backpressure gaps.
    send_frame(8'hA5, 1'b1, -1, -1);
    send_frame(8'h96, 1'b1, -1, -1);
    sweep("gap_out", 8'h96, 1'b0, 8'h00);

    // Abort after 5 bits with a valid bit in the abort cycle.
    send_frame(8'h0F, 1'b0, 5, -1);
    sweep("abort_keep", 8'h96, 1'b0, 8'h00);
    send_frame(8'h5A, 1'b0, -1, -1);

    // Reset after 3 bits of a frame.
    @(negedge prog_clk);
    cfg_start = 1'b1;
    @(negedge prog_clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prog_valid = 1'b1;
      prog_in    = 1'b1;
      @(negedge prog_clk);
    end
    prog_valid = 1'b0;
    #2 prog_rst_n = 1'b0;
    #1;
    chk("frst_busy", busy_a, 0);
    chk("frst_ready", ready_a, 0);
    sweep("frst_out", 8'h00, 1'b0, 8'h00);
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    @(negedge prog_clk);
    chk("frst_idle", busy_a, 0);

    // cfg_start during SHIFT must not restart the count.
    send_frame(8'hC3, 1'b0, -1, 3);
    sweep("start_busy_out", 8'hC3, 1'b0, 8'h00);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
